handshake_monitor: RTL and testbench
====================================

Name: handshake_monitor

Overview:
- Synthesizable passive monitor for a valid/ready stream link. It detects protocol violations and counts transfers.
- It latches the first failure and produces a registered pass flag. That flag drives an assertion checker's test input in simulation and a status register in hardware.
- It sits beside any stream interface and never drives the link.

Parameters:
- WIDTH, 32, data bus width observed.
- TIMEOUT, 1024, stall length in cycles (valid=1, ready=0) flagged as a hang; 0 disables the timeout check.
- CNT_WIDTH, 16, width of the saturating error and transfer counters.

Ports:
- clk  input  1  clock, rising edge.
- srst  input  1  synchronous reset, active high.
- clr  input  1  synchronous clear of error status and counters; no effect on link tracking.
- en  input  1  monitoring enable; when 0, no checks fire and no counts advance, but link tracking continues.
- mon_valid  input  1  observed valid.
- mon_ready  input  1  observed ready.
- mon_data  input  WIDTH  observed data.
- ok  output  1  1 until the first violation, then sticky 0.
- first_err  output  3  one-hot code of the first violation (bit0 DROP, bit1 DATA_CHANGE, bit2 TIMEOUT).
- err_flags  output  3  OR-accumulated violation flags.
- err_count  output  CNT_WIDTH  saturating count of cycles with at least one violation.
- xfer_count  output  CNT_WIDTH  saturating count of transfers (valid & ready).

Behaviour:
- Reset: ok=1, first_err=0, err_flags=0, err_count=0, xfer_count=0, FSM=IDLE, stall counter=0, captured data=0.
- Reset takes priority over everything, including mid-stall; link tracking restarts in IDLE.
- FSM, evaluated each rising edge:
  - IDLE -> STALL when valid=1 and ready=0. mon_data is captured, and the stall counter is set to 1.
  - IDLE stays in IDLE on valid & ready (transfer) or on valid=0.
  - STALL -> IDLE on valid & ready (transfer).
  - STALL -> IDLE on valid=0; this is a DROP violation.
  - STALL stays in STALL on valid=1, ready=0. The stall counter increments, saturating at TIMEOUT.
- Checks are combinational on the current sample and only valid while in STALL with en=1:
  - DROP: valid=0.
  - DATA_CHANGE: valid=1 and mon_data differs from the captured data. The captured data is not updated, so each further differing cycle is also flagged.
  - TIMEOUT: the stall counter increments to exactly TIMEOUT on this edge. It fires once per stall and does not re-fire while saturated.
- DATA_CHANGE and TIMEOUT may fire in the same cycle. That cycle sets both flags and counts as 1 in err_count.
- Latency: a violation sampled at edge N is visible on the outputs after edge N (one-cycle registered).
  - ok falls to 0.
  - err_flags ORs in the new flags.
  - err_count increments by 1, saturating at all-ones.
  - first_err loads only if it is currently 0. Simultaneous first violations load all flags of that cycle.
- xfer_count increments on every valid & ready with en=1, saturating at all-ones.
- clr=1 (synchronous) has priority over a same-cycle violation or transfer. It forces ok=1 and zeroes first_err, err_flags, err_count and xfer_count; the event in that cycle is discarded. FSM, stall counter and captured data are unaffected.
- en=0 mid-stall: the FSM still follows the link. Checks resume when en returns to 1; a stall already past TIMEOUT does not fire late.
- ready=1 with valid=0 is legal and produces no event.

Optional Feature:
- Macro: HANDSHAKE_MONITOR_STAMP_EN.
- Defined:
  - Adds output first_stamp, 32 bits.
  - A free-running 32-bit cycle counter, reset to 0 by srst and not affected by clr, wraps at 2^32.
  - Its value is captured into first_stamp on the edge that loads first_err.
  - first_stamp resets to 0 and clears on clr.
- Undefined: no stamp counter and no first_stamp port; all other behaviour is identical.

Test Plan:
- Clean traffic: 10 back-to-back transfers of data 0..9 with valid=ready=1 -> xfer_count=10, ok=1, err_flags=0.
- Drop: assert valid=1, ready=0 with data 0xA5 for 3 cycles, then deassert valid -> one cycle later ok=0, first_err=3'b001, err_count=1.
- Data change: stall on data 0x11, change data to 0x22 for 2 cycles, then ready=1 -> err_flags=3'b010, err_count=2, xfer_count=1, FSM back to IDLE.
- Timeout with TIMEOUT=4: stall for 10 cycles, then transfer -> TIMEOUT flagged exactly once, on the 4th stall cycle; err_count=1, first_err=3'b100, xfer_count=1.
- Clear priority: during a stall, apply clr=1 in the same cycle valid drops -> all status 0, ok=1. A subsequent clean transfer gives xfer_count=1.
- Stamp (macro on): 5 idle cycles after reset, then a drop sampled at cycle 8 -> first_stamp=8. After clr, first_stamp=0, and a new violation at cycle 20 captures 20.

Source files
------------

// File: rtl/handshake_monitor.sv
// rtl/handshake_monitor.sv - passive valid/ready link monitor: violation latch, pass flag, saturating counters
// Optional macro HANDSHAKE_MONITOR_STAMP_EN adds a free-running cycle stamp of the first violation (first_stamp).
module handshake_monitor #(
  parameter int WIDTH     = 32,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 mon_valid,
  input  logic                 mon_ready,
  input  logic [WIDTH-1:0]     mon_data,
  output logic                 ok,
  output logic [2:0]           first_err,
  output logic [2:0]           err_flags,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] xfer_count
`ifdef HANDSHAKE_MONITOR_STAMP_EN
  ,
  output logic [31:0]          first_stamp
`endif
);

  localparam int SW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [SW-1:0] TO_MAX = SW'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, STALL} state_t;

  state_t           state, state_nx;
  logic [SW-1:0]    stall_cnt;
  logic [WIDTH-1:0] cap_data;
  logic             stall_start, stall_hold;
  logic             drop, dchg, tmo;
  logic [2:0]       ev;

  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= IDLE;
      stall_cnt <= '0;
      cap_data  <= '0;
    end else begin
      state <= state_nx;
      if (stall_start) begin
        cap_data  <= mon_data;
        stall_cnt <= SW'(1);
      end else if (stall_hold && (stall_cnt < TO_MAX)) begin
        stall_cnt <= stall_cnt + SW'(1);
      end
    end
  end

  // Checks are raw here; en gating is applied once when forming ev.
  always_comb begin
    state_nx    = state;
    stall_start = 1'b0;
    stall_hold  = 1'b0;
    drop        = 1'b0;
    dchg        = 1'b0;
    tmo         = 1'b0;
    case (state)
      IDLE: begin
        if (mon_valid && !mon_ready) begin
          state_nx    = STALL;
          stall_start = 1'b1;
        end
      end
      STALL: begin
        if (!mon_valid) begin
          state_nx = IDLE;
          drop     = 1'b1;
        end else begin
          dchg = (mon_data != cap_data);
          if (mon_ready) begin
            state_nx = IDLE;
          end else begin
            stall_hold = 1'b1;
            tmo = TO_EN && (stall_cnt != TO_MAX) && ((stall_cnt + SW'(1)) == TO_MAX);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign ev = en ? {tmo, dchg, drop} : 3'b000;

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      ok         <= 1'b1;
      first_err  <= 3'b000;
      err_flags  <= 3'b000;
      err_count  <= '0;
      xfer_count <= '0;
    end else begin
      if (|ev) begin
        ok        <= 1'b0;
        err_flags <= err_flags | ev;
        if (err_count != CNT_MAX) err_count <= err_count + CNT_WIDTH'(1);
        if (first_err == 3'b000) first_err <= ev;
      end
      if (en && mon_valid && mon_ready && (xfer_count != CNT_MAX))
        xfer_count <= xfer_count + CNT_WIDTH'(1);
    end
  end

`ifdef HANDSHAKE_MONITOR_STAMP_EN
  logic [31:0] cyc_cnt;

  // The cycle counter survives clr so stamps stay relative to the last reset.
  always_ff @(posedge clk) begin
    if (srst) cyc_cnt <= '0;
    else      cyc_cnt <= cyc_cnt + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (srst || clr)                      first_stamp <= '0;
    else if ((|ev) && first_err == 3'b000) first_stamp <= cyc_cnt;
  end
`endif

endmodule

// File: tb/tb_handshake_monitor.sv
// tb/tb_handshake_monitor.sv - randomized and directed bench for handshake_monitor against a behavioural model
// Define HANDSHAKE_MONITOR_STAMP_EN to also exercise first_stamp.
module tb_handshake_monitor;
  localparam int W = 8;
  localparam int TO = 4;
  localparam int CW = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic srst, clr, en, mon_valid, mon_ready;
  logic [W-1:0] mon_data;
  logic ok;
  logic [2:0] first_err, err_flags;
  logic [CW-1:0] err_count, xfer_count;
`ifdef HANDSHAKE_MONITOR_STAMP_EN
  logic [31:0] first_stamp;
`endif

  int total = 0;
  int bad = 0;

  // Behavioural model state
  bit        m_stall;
  bit [W-1:0] m_cap;
  int        m_len;
  bit        m_ok;
  bit [2:0]  m_first, m_flags;
  int        m_errc, m_xfer;
  bit [31:0] m_cyc, m_stamp;

  handshake_monitor #(.WIDTH(W), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .srst(srst), .clr(clr), .en(en),
    .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_data(mon_data),
    .ok(ok), .first_err(first_err), .err_flags(err_flags),
    .err_count(err_count), .xfer_count(xfer_count)
`ifdef HANDSHAKE_MONITOR_STAMP_EN
    , .first_stamp(first_stamp)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit [2:0] ev;
    if (srst) begin
      m_stall = 0; m_cap = '0; m_len = 0; m_ok = 1; m_first = 0; m_flags = 0;
      m_errc = 0; m_xfer = 0; m_cyc = 0; m_stamp = 0;
      return;
    end
    ev = 3'b000;
    if (m_stall && en) begin
      if (!mon_valid) ev[0] = 1'b1;
      else begin
        if (mon_data != m_cap) ev[1] = 1'b1;
        if (!mon_ready && (m_len + 1 == TO)) ev[2] = 1'b1;
      end
    end
    if (clr) begin
      m_ok = 1; m_first = 0; m_flags = 0; m_errc = 0; m_xfer = 0; m_stamp = 0;
    end else begin
      if (ev != 0) begin
        m_ok = 0;
        m_flags |= ev;
        m_errc = (m_errc < CMAX) ? m_errc + 1 : CMAX;
        if (m_first == 0) begin m_first = ev; m_stamp = m_cyc; end
      end
      if (en && mon_valid && mon_ready) m_xfer = (m_xfer < CMAX) ? m_xfer + 1 : CMAX;
    end
    if (m_stall) begin
      if (!mon_valid || mon_ready) m_stall = 0;
      else m_len++;
    end else if (mon_valid && !mon_ready) begin
      m_stall = 1; m_cap = mon_data; m_len = 1;
    end
    m_cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit v, input bit r, input bit [W-1:0] d);
    mon_valid = v; mon_ready = r; mon_data = d;
    tick();
  endtask

  task automatic do_reset();
    srst = 1; clr = 0; en = 1; mon_valid = 0; mon_ready = 0; mon_data = '0;
    tick();
    srst = 0;
  endtask

  task automatic test_reset();
    srst = 1; clr = 0; en = 1; mon_valid = 1; mon_ready = 0; mon_data = 8'h3C;
    tick(); tick();
    srst = 0;
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL reset_ok got=%0b want=1", ok); end
    total++; if (first_err !== 3'b000) begin bad++; $display("FAIL reset_first got=%0b want=0", first_err); end
    total++; if (err_flags !== 3'b000) begin bad++; $display("FAIL reset_flags got=%0b want=0", err_flags); end
    total++; if (err_count !== 4'd0) begin bad++; $display("FAIL reset_errc got=%0d want=0", err_count); end
    total++; if (xfer_count !== 4'd0) begin bad++; $display("FAIL reset_xfer got=%0d want=0", xfer_count); end
    drive(1, 0, 8'h10); drive(1, 0, 8'h10);
    srst = 1; drive(0, 0, 8'h00);
    srst = 0;
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL reset_midstall_ok got=%0b want=1", ok); end
    drive(0, 0, 8'h00);
    total++; if (ok !== 1'b1 || err_count !== 4'd0) begin
      bad++; $display("FAIL reset_restart_idle got ok=%0b errc=%0d want ok=1 errc=0", ok, err_count);
    end
  endtask

  task automatic test_clean();
    do_reset();
    for (int i = 0; i < 10; i++) drive(1, 1, W'(i));
    drive(0, 0, 8'h00);
    total++; if (xfer_count !== 4'd10) begin bad++; $display("FAIL clean_xfer got=%0d want=10", xfer_count); end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL clean_ok got=%0b want=1", ok); end
    total++; if (err_flags !== 3'b000) begin bad++; $display("FAIL clean_flags got=%0b want=0", err_flags); end
  endtask

  task automatic test_drop();
    do_reset();
    for (int i = 0; i < 3; i++) drive(1, 0, 8'hA5);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL drop_pre_ok got=%0b want=1", ok); end
    drive(0, 0, 8'hA5);
    total++; if (ok !== 1'b0) begin bad++; $display("FAIL drop_ok got=%0b want=0", ok); end
    total++; if (first_err !== 3'b001) begin bad++; $display("FAIL drop_first got=%0b want=001", first_err); end
    total++; if (err_count !== 4'd1) begin bad++; $display("FAIL drop_errc got=%0d want=1", err_count); end
  endtask

  task automatic test_data_change();
    do_reset();
    drive(1, 0, 8'h11);
    drive(1, 0, 8'h22);
    drive(1, 0, 8'h22);
    drive(1, 1, 8'h11);
    drive(0, 0, 8'h00);
    total++; if (err_flags !== 3'b010) begin bad++; $display("FAIL dchg_flags got=%0b want=010", err_flags); end
    total++; if (err_count !== 4'd2) begin bad++; $display("FAIL dchg_errc got=%0d want=2", err_count); end
    total++; if (xfer_count !== 4'd1) begin bad++; $display("FAIL dchg_xfer got=%0d want=1", xfer_count); end
    total++; if (first_err !== 3'b010) begin bad++; $display("FAIL dchg_first got=%0b want=010", first_err); end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      drive(1, 0, 8'h5A);
      total++;
      if (err_count !== CW'((k >= TO) ? 1 : 0)) begin
        bad++; $display("FAIL timeout_stall%0d got errc=%0d want=%0d", k, err_count, (k >= TO) ? 1 : 0);
      end
    end
    drive(1, 1, 8'h5A);
    total++; if (err_count !== 4'd1) begin bad++; $display("FAIL timeout_errc got=%0d want=1", err_count); end
    total++; if (first_err !== 3'b100) begin bad++; $display("FAIL timeout_first got=%0b want=100", first_err); end
    total++; if (xfer_count !== 4'd1) begin bad++; $display("FAIL timeout_xfer got=%0d want=1", xfer_count); end
  endtask

  task automatic test_clear();
    do_reset();
    drive(1, 0, 8'h01); drive(0, 0, 8'h00);
    drive(1, 0, 8'h02); drive(1, 0, 8'h02);
    clr = 1; drive(0, 0, 8'h02); clr = 0;
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL clear_ok got=%0b want=1", ok); end
    total++; if ({first_err, err_flags, err_count, xfer_count} !== 14'd0) begin
      bad++; $display("FAIL clear_status got first=%0b flags=%0b errc=%0d xfer=%0d want all 0",
                      first_err, err_flags, err_count, xfer_count);
    end
    drive(1, 1, 8'h03);
    total++; if (xfer_count !== 4'd1 || ok !== 1'b1) begin
      bad++; $display("FAIL clear_after_xfer got xfer=%0d ok=%0b want xfer=1 ok=1", xfer_count, ok);
    end
  endtask

  task automatic test_enable();
    do_reset();
    en = 0;
    for (int i = 0; i < 6; i++) drive(1, 0, W'(i));
    drive(0, 0, 8'h00);
    drive(1, 1, 8'h07);
    for (int i = 0; i < 6; i++) drive(1, 0, 8'h44);
    en = 1;
    for (int i = 0; i < 3; i++) drive(1, 0, 8'h44);
    drive(1, 1, 8'h44);
    total++; if (ok !== 1'b1 || err_count !== 4'd0) begin
      bad++; $display("FAIL enable_no_err got ok=%0b errc=%0d want ok=1 errc=0", ok, err_count);
    end
    total++; if (xfer_count !== 4'd1) begin bad++; $display("FAIL enable_xfer got=%0d want=1", xfer_count); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) drive(1, 1, W'(i));
    total++; if (xfer_count !== 4'd15) begin bad++; $display("FAIL sat_xfer got=%0d want=15", xfer_count); end
    for (int i = 0; i < 20; i++) begin drive(1, 0, 8'h00); drive(0, 0, 8'h00); end
    total++; if (err_count !== 4'd15) begin bad++; $display("FAIL sat_errc got=%0d want=15", err_count); end
  endtask

`ifdef HANDSHAKE_MONITOR_STAMP_EN
  task automatic test_stamp();
    do_reset();
    for (int i = 0; i < 5; i++) drive(0, 0, 8'h00);
    drive(1, 0, 8'h66); drive(1, 0, 8'h66); drive(1, 0, 8'h66);
    drive(0, 0, 8'h00);
    total++; if (first_stamp !== 32'd8) begin bad++; $display("FAIL stamp_first got=%0d want=8", first_stamp); end
    clr = 1; drive(0, 0, 8'h00); clr = 0;
    total++; if (first_stamp !== 32'd0) begin bad++; $display("FAIL stamp_clr got=%0d want=0", first_stamp); end
    for (int i = 10; i < 18; i++) drive(0, 0, 8'h00);
    drive(1, 0, 8'h77); drive(1, 0, 8'h77);
    drive(0, 0, 8'h00);
    total++; if (first_stamp !== 32'd20) begin bad++; $display("FAIL stamp_second got=%0d want=20", first_stamp); end
  endtask
`endif

  task automatic test_random();
    logic [63:0] got, exp;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      srst = ($urandom_range(0, 99) == 0);
      clr = ($urandom_range(0, 99) < 3);
      en = ($urandom_range(0, 9) != 0);
      mon_valid = ($urandom_range(0, 9) < 7);
      mon_ready = ($urandom_range(0, 9) < 4);
      mon_data = W'($urandom_range(0, 3));
      tick();
      got = {35'd0, ok, first_err, err_flags, err_count, xfer_count};
      exp = {35'd0, m_ok, m_first, m_flags, CW'(m_errc), CW'(m_xfer)};
`ifdef HANDSHAKE_MONITOR_STAMP_EN
      got[63:32] = first_stamp;
      exp[63:32] = m_stamp;
`endif
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL random_cycle%0d got=%h want=%h", i, got, exp);
      end
    end
    srst = 0; clr = 0; en = 1;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_drop();
    test_data_change();
    test_timeout();
    test_clear();
    test_enable();
    test_saturation();
`ifdef HANDSHAKE_MONITOR_STAMP_EN
    test_stamp();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
